// File: rtl/fft_out_reorder_if.sv
// Handshake/data bundle between the FFT output stream, the reorder buffer and its consumer.
interface fft_out_reorder_if #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
);
  logic                       in_valid;
  logic [FLOAT_PRECISION-1:0] in_re;
  logic [FLOAT_PRECISION-1:0] in_im;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [FLOAT_PRECISION-1:0] out_re;
  logic [FLOAT_PRECISION-1:0] out_im;
  logic [logn-1:0]            out_idx;
  logic                       out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong buffer turning bit-reversed FFT output frames into natural order with valid/ready output.
// Optional sticky overflow flag port 'ovf' when REORDER_OVF_FLAG_EN is defined.
module fft_out_reorder #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave io
`ifdef REORDER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N = 1 << logn;
  localparam int unsigned W = 2 * FLOAT_PRECISION;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [logn-1:0]            rcnt_q, rcnt_d;
  logic [logn-1:0]            wcnt_q, wcnt_d;
  logic                       wbank_q, wbank_d;
  logic                       rbank_q, rbank_d;
  logic [1:0]                 full_q, full_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [logn-1:0]            rd_idx_q, rd_idx_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [logn-1:0]            out_idx_q, out_idx_d;
  logic [FLOAT_PRECISION-1:0] out_re_q, out_re_d;
  logic [FLOAT_PRECISION-1:0] out_im_q, out_im_d;

  logic [W-1:0]               mem [2*N];
  logic [W-1:0]               rd_data_q;

  logic                       wr_en, wr_done;
  logic [logn-1:0]            wr_addr;
  logic                       rd_en, rd_fin, adv;
  logic [logn-1:0]            rd_addr;

  function automatic logic [logn-1:0] bitrev(input logic [logn-1:0] v);
    logic [logn-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < logn; i++) r[i] = v[logn-1-i];
    return r;
  endfunction

  // Write side
  always_comb begin
    io.in_ready = !full_q[wbank_q];
    wr_en       = io.in_valid && io.in_ready;
    wr_addr     = bitrev(wcnt_q);
    wr_done     = wr_en && (wcnt_q == logn'(N-1));
    wcnt_d      = wr_en ? wcnt_q + logn'(1) : wcnt_q;
    wbank_d     = wbank_q ^ wr_done;
  end

  // Two-stage read pipe (memory read register, output register) advances as one on a free output slot.
  assign adv    = !out_valid_q || io.out_ready;
  assign rd_fin = (state_q == DRAIN) && out_valid_q && io.out_ready && out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rd_en   = 1'b0;
    rd_addr = rcnt_q;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q] && adv) begin
          rd_en   = 1'b1;
          rd_addr = '0;
          rcnt_d  = logn'(1);
          state_d = READ;
        end
      end
      READ: begin
        if (adv) begin
          rd_en  = 1'b1;
          rcnt_d = rcnt_q + logn'(1);
          if (rcnt_q == logn'(N-1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d  = rd_valid_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (adv) begin
      rd_valid_d  = rd_en;
      rd_idx_d    = rd_addr;
      out_valid_d = rd_valid_q;
      out_last_d  = rd_valid_q && (rd_idx_q == logn'(N-1));
      if (rd_valid_q) begin
        out_idx_d = rd_idx_q;
        out_re_d  = rd_data_q[W-1:FLOAT_PRECISION];
        out_im_d  = rd_data_q[FLOAT_PRECISION-1:0];
      end
    end
    // Clear applied after set so a freed bank always ends up empty.
    full_d = full_q;
    if (wr_done) full_d[wbank_q] = 1'b1;
    if (rd_fin)  full_d[rbank_q] = 1'b0;
    rbank_d = rbank_q ^ rd_fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      rd_valid_q  <= rd_valid_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank_q, wr_addr}] <= {io.in_re, io.in_im};
    if (rd_en) rd_data_q <= mem[{rbank_q, rd_addr}];
  end

  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_idx   = out_idx_q;
  assign io.out_re    = out_re_q;
  assign io.out_im    = out_im_q;

`ifdef REORDER_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb ovf_d = ovf_q | (io.in_valid && !io.in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // A bank being completed can never be the one being freed: it must be empty to accept writes.
  assert property (@(posedge clk) disable iff (rst)
    !(wr_done && rd_fin && (wbank_q == rbank_q)));

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: logn=3 instance for handshake/order/reset cases, logn=8 for a full frame.
`timescale 1ns/1ps
module tb_fft_out_reorder;
  localparam int FP = 64;

  typedef struct packed {
    logic [63:0] re;
    logic [63:0] im;
    logic [7:0]  idx;
    logic        last;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.FLOAT_PRECISION(FP), .logn(3)) i3 ();
  fft_out_reorder_if #(.FLOAT_PRECISION(FP), .logn(8)) i8 ();

`ifdef REORDER_OVF_FLAG_EN
  logic ovf3, ovf8;
`endif

  fft_out_reorder #(.FLOAT_PRECISION(FP), .logn(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .io  (i3)
`ifdef REORDER_OVF_FLAG_EN
    ,
    .ovf (ovf3)
`endif
  );

  fft_out_reorder #(.FLOAT_PRECISION(FP), .logn(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .io  (i8)
`ifdef REORDER_OVF_FLAG_EN
    ,
    .ovf (ovf8)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  smp_t act3[$];
  smp_t exp3[$];
  smp_t act8[$];
  bit   rand_rdy = 1'b0;
  bit   rdy_fix  = 1'b1;
  int   stab_viol = 0;
  bit   hold_pending = 1'b0;
  logic [130:0] held_v;
  smp_t mon3_s, mon8_s;

  // Consumer ready for the small instance; changes 2 ns after the edge.
  always begin
    i3.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    @(posedge clk);
    #2;
  end

  always @(negedge clk) begin
    if (rst) begin
      act3.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && (!i3.out_valid || {i3.out_re, i3.out_im, i3.out_idx} !== held_v))
        stab_viol++;
      if (i3.out_valid && i3.out_ready) begin
        mon3_s.re = i3.out_re; mon3_s.im = i3.out_im;
        mon3_s.idx = 8'(i3.out_idx); mon3_s.last = i3.out_last;
        act3.push_back(mon3_s);
        hold_pending = 1'b0;
      end else if (i3.out_valid) begin
        held_v = {i3.out_re, i3.out_im, i3.out_idx};
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) act8.delete();
    else if (i8.out_valid && i8.out_ready) begin
      mon8_s.re = i8.out_re; mon8_s.im = i8.out_im;
      mon8_s.idx = i8.out_idx; mon8_s.last = i8.out_last;
      act8.push_back(mon8_s);
    end
  end

  function automatic int unsigned brev(input int unsigned v, input int unsigned bits);
    int unsigned r = 0;
    for (int unsigned i = 0; i < bits; i++)
      if (v[i]) r = r | (32'd1 << (bits - 1 - i));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One logn=3 frame: sample for natural index k carries re = tag*16+k, sent in bit-reversed order.
  task automatic feed3(input int tag, input bit strict, input bit expect_out);
    smp_t e;
    if (expect_out)
      for (int k = 0; k < 8; k++) begin
        e.re = 64'(tag * 16 + k); e.im = ~e.re; e.idx = 8'(k); e.last = (k == 7);
        exp3.push_back(e);
      end
    for (int j = 0; j < 8; j++) begin
      i3.in_valid = 1'b0;
      if (strict) begin
        chk($sformatf("in_ready_t%0d_s%0d", tag, j), i3.in_ready, 1);
      end else begin
        int w;
        w = 0;
        while (i3.in_ready !== 1'b1 && w < 200) begin tick(); w++; end
        chk($sformatf("in_ready_wait_t%0d_s%0d", tag, j), i3.in_ready, 1);
      end
      i3.in_valid = 1'b1;
      i3.in_re    = 64'(tag * 16 + int'(brev(j, 3)));
      i3.in_im    = ~i3.in_re;
      tick();
    end
    i3.in_valid = 1'b0;
  endtask

  task automatic check3(input int n, input string tag);
    smp_t a, e;
    int   w;
    w = 0;
    while (act3.size() < n && w < 400) begin tick(); w++; end
    chk({tag, "_count"}, 64'(act3.size() >= n), 1);
    for (int i = 0; i < n; i++) begin
      e = exp3.pop_front();
      if (act3.size() > 0) a = act3.pop_front();
      else a = '0;
      checks++;
      assert (a === e) else begin
        errors++;
        $error("FAIL %s_%0d got re=%0h im=%0h idx=%0d last=%b exp re=%0h im=%0h idx=%0d last=%b",
               tag, i, a.re, a.im, a.idx, a.last, e.re, e.im, e.idx, e.last);
      end
    end
  endtask

  initial begin
    smp_t a, e;
    int   w;
    i3.in_valid = 1'b0; i3.in_re = '0; i3.in_im = '0;
    i8.in_valid = 1'b0; i8.in_re = '0; i8.in_im = '0; i8.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", i3.out_valid, 0);
    chk("rst_out_last", i3.out_last, 0);
    chk("rst_out_idx", 64'(i3.out_idx), 0);
    chk("rst_out_re", i3.out_re, 0);
    chk("rst_in_ready", i3.in_ready, 1);
`ifdef REORDER_OVF_FLAG_EN
    chk("rst_ovf", ovf3, 0);
`endif
    rst = 1'b0;
    tick();

    // Single frame and first-output latency
    feed3(1, 1'b1, 1'b1);
    chk("lat_c0_valid", i3.out_valid, 0);
    tick();
    chk("lat_c1_valid", i3.out_valid, 0);
    tick();
    chk("lat_c2_valid", i3.out_valid, 1);
    chk("lat_c2_idx", 64'(i3.out_idx), 0);
    check3(8, "f1");

    // Two back-to-back frames
    feed3(2, 1'b1, 1'b1);
    feed3(3, 1'b1, 1'b1);
    check3(16, "f23");

    // Both banks filled under backpressure, 17th sample dropped
    rdy_fix = 1'b0;
    feed3(4, 1'b1, 1'b1);
    feed3(5, 1'b1, 1'b1);
    chk("full_in_ready", i3.in_ready, 0);
    i3.in_valid = 1'b1; i3.in_re = 64'hDEAD; i3.in_im = 64'hBEEF;
    tick();
    i3.in_valid = 1'b0;
`ifdef REORDER_OVF_FLAG_EN
    chk("ovf_set", ovf3, 1);
`endif
    chk("stall_valid", i3.out_valid, 1);
    chk("stall_re", i3.out_re, 64'h40);
    rdy_fix = 1'b1;
    check3(8, "f4");
    chk("ready_back", i3.in_ready, 1);
    check3(8, "f5");
    feed3(6, 1'b1, 1'b1);
    check3(8, "f6");

    // Random consumer backpressure over four frames
    rand_rdy = 1'b1;
    feed3(7, 1'b0, 1'b1);
    feed3(8, 1'b0, 1'b1);
    feed3(9, 1'b0, 1'b1);
    feed3(10, 1'b0, 1'b1);
    check3(32, "rnd");
    rdy_fix = 1'b0;
    rand_rdy = 1'b0;
    chk("hold_stable", 64'(stab_viol), 0);

    // Reset with both banks full and a stalled output
    feed3(11, 1'b1, 1'b0);
    feed3(12, 1'b1, 1'b0);
    chk("pre_rst_valid", i3.out_valid, 1);
    chk("pre_rst_ready", i3.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rstA_out_valid", i3.out_valid, 0);
    chk("rstA_in_ready", i3.in_ready, 1);
    chk("rstA_out_re", i3.out_re, 0);
    tick();
    rst = 1'b0;
    rdy_fix = 1'b1;
    tick();

    // Reset after 5 writes of a frame, then a clean frame
    for (int j = 0; j < 5; j++) begin
      i3.in_valid = 1'b1; i3.in_re = 64'hBAD0 + 64'(j); i3.in_im = '0;
      tick();
    end
    i3.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstB_out_valid", i3.out_valid, 0);
    chk("rstB_in_ready", i3.in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    feed3(13, 1'b1, 1'b1);
    check3(8, "post_rst");
    repeat (20) tick();
    chk("no_extra_out", 64'(act3.size()), 0);

    // logn=8 full frame against the bit-reverse model
    for (int j = 0; j < 256; j++) begin
      i8.in_valid = 1'b1;
      i8.in_re    = 64'h8000 + 64'(brev(j, 8));
      i8.in_im    = ~i8.in_re;
      tick();
    end
    i8.in_valid = 1'b0;
    w = 0;
    while (act8.size() < 256 && w < 600) begin tick(); w++; end
    chk("n256_count", 64'(act8.size()), 256);
    for (int k = 0; k < 256; k++) begin
      e.re = 64'h8000 + 64'(k); e.im = ~e.re; e.idx = 8'(k); e.last = (k == 255);
      if (act8.size() > 0) a = act8.pop_front();
      else a = '0;
      checks++;
      assert (a === e) else begin
        errors++;
        $error("FAIL n256_%0d got re=%0h idx=%0d last=%b exp re=%0h idx=%0d last=%b",
               k, a.re, a.idx, a.last, e.re, e.idx, e.last);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sits directly downstream of the FFT core.
- Consumes the FFT output stream (out_valid, fo_re, fo_im), which arrives in bit-reversed order, and re-emits each frame of N = 2^logn complex samples in natural order.
- Ping-pong double buffer: the FFT writes one frame while the consumer reads the previous one, with a valid/ready handshake on the output side.

Parameters:
- FLOAT_PRECISION, 64, width of each real/imag word.
- logn, 8, log2 of frame length N (8 for FALCON512, 9 for FALCON1024).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample strobe; wired to FFT out_valid.
- in_re  in  FLOAT_PRECISION  real part; wired to FFT fo_re.
- in_im  in  FLOAT_PRECISION  imag part; wired to FFT fo_im.
- in_ready  out  1  a bank is free to accept writes.
- out_valid  out  1  out_re/out_im/out_idx hold a valid sample.
- out_ready  in  1  consumer accepts the sample this cycle.
- out_re  out  FLOAT_PRECISION  natural-order real part.
- out_im  out  FLOAT_PRECISION  natural-order imag part.
- out_idx  out  logn  natural index of the presented sample.
- out_last  out  1  high with the sample at out_idx = N-1.

Behaviour:
- Storage: two banks (B0, B1), each N x 2*FLOAT_PRECISION. Synchronous write, synchronous 1-cycle read. Per-bank full flag.
- Write side:
  - wcnt (logn bits) and wbank pointer.
  - On in_valid && in_ready: write {in_re, in_im} to bank[wbank] at address bitrev(wcnt), then wcnt++.
  - At wcnt = N-1: set full[wbank], toggle wbank, wcnt wraps to 0.
  - in_ready = !full[wbank].
- Read side FSM, states IDLE, READ, DRAIN:
  - IDLE: if full[rbank], issue read of address 0 and go to READ.
  - READ: a read is issued whenever the output register is empty or out_ready is high. rcnt increments per issued read.
  - After the read of address N-1 is issued, go to DRAIN.
  - DRAIN: on acceptance of the last sample (out_valid && out_ready && out_last), clear full[rbank], toggle rbank, return to IDLE.
- Latency:
  - First out_valid rises 2 cycles after the cycle in which the last input write of a frame occurs, given the other bank is idle.
  - Thereafter 1 sample per cycle while out_ready stays high.
- Output register: holds its value and out_valid stays high while out_ready is low. No data is lost or duplicated under backpressure.
- Simultaneous events:
  - Write to one bank and read from the other in the same cycle is supported.
  - Setting full[x] on the write side and clearing full[y] on the read side in the same cycle are independent.
  - If a write completes bank x in the same cycle the read side frees bank x, the clear takes precedence only for the freed bank. This cannot occur for the same bank by construction; assert in simulation.
- Overflow: in_valid while in_ready is low drops the sample; wcnt does not advance.
- Reset (any time, including mid-frame):
  - wcnt, rcnt, wbank, rbank = 0; full flags = 0; FSM = IDLE.
  - out_valid = 0, out_last = 0, out_idx = 0, out_re = out_im = 0; in_ready = 1 (after reset).
  - Partial frames are discarded. Memory contents are not cleared.

Optional Feature:
- Macro REORDER_OVF_FLAG_EN.
- Defined: adds output port ovf (1 bit), reset 0. Set sticky on any cycle with in_valid && !in_ready; cleared only by rst.
- Undefined: port absent; dropped samples are silent.

Test Plan:
- logn=3. Feed one frame fo_re = 0..7 in bit-reversed arrival order (0,4,2,6,1,5,3,7), out_ready=1 -> out_re = 0..7, out_idx = 0..7, out_last only with out_idx 7; first out_valid 2 cycles after the 8th write.
- Two back-to-back frames (16 consecutive in_valid cycles), out_ready=1 -> in_ready never drops; both frames emitted in natural order, contiguous.
- Three frames back-to-back with out_ready=0 -> in_ready falls after the 16th write. A 17th sample is dropped (ovf=1 when REORDER_OVF_FLAG_EN). Raising out_ready drains frame 1, then in_ready returns to 1.
- Random out_ready toggling (50%) over 4 frames -> output sequence identical to the out_ready=1 case; out_re/out_im stable while out_valid && !out_ready.
- Assert rst after 5 writes, then send a full frame -> only the new frame appears; out_valid=0 and in_ready=1 immediately during reset.
- logn=8: one frame of 256 samples -> natural-order output verified against a reference bit-reverse model.
